seven_segment_capture: RTL

- Captures a multiplexed, active-low four-digit seven-segment scan bus (anode strobes plus segment lines) and reconstructs the displayed 16-bit hex word.
- Decodes each segment pattern back to its nibble using the team's hex-to-segment encoding, run in reverse.
- Filters scan glitches and flags undecodable digits.
- Hands complete frames to downstream logic over a valid/ready interface.
- Sits at the board-test/loopback boundary of the ALU, downstream of the display driver pins.

---
 rtl/sevseg_pkg.sv | 33 +++
 rtl/seven_segment_pattern_decoder.sv | 40 ++++
 rtl/seven_segment_capture.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scan capture: segment patterns, digit count, FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sevseg_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low segment patterns, bit 6 = segment a ... bit 0 = segment g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_COUNT,
        CAP_CAPTURED
    } cap_state_e;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Reverse hex-to-segment decode of one active-low pattern into nibble plus blank/error flags.
// Latency: combinational.
// Backpressure: none.
module seven_segment_pattern_decoder
    import sevseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    // Table lookup; anything neither in the hex table nor blank is flagged as an error
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Rebuilds a 16-bit hex word from an active-low multiplexed 4-digit seven-segment scan bus.
// Latency: 2 (sync) + STABLE_CYCLES + 1 cycles from the last digit's pin change to word_valid.
// Backpressure: valid/ready; a frame completing while word_valid=1 and word_ready=0 is dropped and overrun pulses.
// Optional: define SEVSEG_CAPTURE_DP_EN to add dp_in/dp_out decimal-point capture.
module seven_segment_capture
    import sevseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an_in,
    input  logic [6:0]  seg_in,
`ifdef SEVSEG_CAPTURE_DP_EN
    input  logic        dp_in,
    output logic [3:0]  dp_out,
`endif
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [3:0]  digit_err,
    output logic [3:0]  blank_mask,
    output logic        overrun
);

`ifdef SEVSEG_CAPTURE_DP_EN
    localparam int PIN_W = 12;
`else
    localparam int PIN_W = 11;
`endif
    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    logic [PIN_W-1:0] pins;
    logic [PIN_W-1:0] sync_q, samp_q, prev_q;
    logic             changed;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;
    logic [7:0]       stab_cnt_q, stab_cnt_d;
    cap_state_e       state_q, state_d;
    logic             capture;
    logic [3:0]       dec_nibble;
    logic             dec_blank, dec_err;
    logic [15:0]      slot_nib_q, slot_nib_d;
    logic [3:0]       slot_err_q, slot_err_d, slot_blank_q, slot_blank_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_done;
    logic [15:0]      word_q, word_d;
    logic             valid_q, valid_d, ovr_q, ovr_d;
    logic [3:0]       err_q, err_d, blank_q, blank_d;
`ifdef SEVSEG_CAPTURE_DP_EN
    logic [3:0]       slot_dp_q, slot_dp_d, dp_q, dp_d;

    assign pins   = {dp_in, an_in, seg_in};
    assign dp_out = dp_q;
`else
    assign pins   = {an_in, seg_in};
`endif

    assign an_s       = samp_q[10:7];
    assign seg_s      = samp_q[6:0];
    assign changed    = (samp_q != prev_q);
    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign digit_err  = err_q;
    assign blank_mask = blank_q;
    assign overrun    = ovr_q;

    seven_segment_pattern_decoder u_dec (
        .seg    (seg_s),
        .nibble (dec_nibble),
        .blank  (dec_blank),
        .err    (dec_err)
    );

    // Stability counter: restarts on any change of the synchronized sample, saturates at STABLE_CYCLES
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (changed) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end
    end

    // Capture FSM: one capture per stable interval, only when exactly one anode is active
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            CAP_IDLE:     if (changed) state_d = CAP_COUNT;
            CAP_COUNT: begin
                if (!changed && stab_cnt_q == STAB_LAST) begin
                    state_d = CAP_CAPTURED;
                    capture = $onehot(~an_s);
                end
            end
            CAP_CAPTURED: if (changed) state_d = CAP_COUNT;
            default:      state_d = CAP_IDLE;
        endcase
    end

    // Slot update and frame completion; the completing digit is merged in the same cycle
    always_comb begin
        slot_nib_d   = slot_nib_q;
        slot_err_d   = slot_err_q;
        slot_blank_d = slot_blank_q;
        seen_d       = seen_q;
`ifdef SEVSEG_CAPTURE_DP_EN
        slot_dp_d    = slot_dp_q;
`endif
        frame_done   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && !an_s[i]) begin
                slot_nib_d[4*i +: 4] = dec_nibble;
                slot_err_d[i]        = dec_err;
                slot_blank_d[i]      = dec_blank;
                seen_d[i]            = 1'b1;
`ifdef SEVSEG_CAPTURE_DP_EN
                slot_dp_d[i]         = ~samp_q[11];
`endif
            end
        end
        if (seen_d == 4'hF) begin
            frame_done = 1'b1;
            seen_d     = '0;
        end
    end

    // Output registers: load a completed frame if the slot is free or being consumed, else drop it
    always_comb begin
        word_d  = word_q;
        err_d   = err_q;
        blank_d = blank_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
`ifdef SEVSEG_CAPTURE_DP_EN
        dp_d    = dp_q;
`endif
        if (frame_done) begin
            if (!valid_q || word_ready) begin
                word_d  = slot_nib_d;
                err_d   = slot_err_d;
                blank_d = slot_blank_d;
                valid_d = 1'b1;
`ifdef SEVSEG_CAPTURE_DP_EN
                dp_d    = slot_dp_d;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            samp_q       <= '0;
            prev_q       <= '0;
            stab_cnt_q   <= '0;
            state_q      <= CAP_IDLE;
            slot_nib_q   <= '0;
            slot_err_q   <= '0;
            slot_blank_q <= '0;
            seen_q       <= '0;
            word_q       <= '0;
            err_q        <= '0;
            blank_q      <= '0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
`ifdef SEVSEG_CAPTURE_DP_EN
            slot_dp_q    <= '0;
            dp_q         <= '0;
`endif
        end else begin
            sync_q       <= pins;
            samp_q       <= sync_q;
            prev_q       <= samp_q;
            stab_cnt_q   <= stab_cnt_d;
            state_q      <= state_d;
            slot_nib_q   <= slot_nib_d;
            slot_err_q   <= slot_err_d;
            slot_blank_q <= slot_blank_d;
            seen_q       <= seen_d;
            word_q       <= word_d;
            err_q        <= err_d;
            blank_q      <= blank_d;
            valid_q      <= valid_d;
            ovr_q        <= ovr_d;
`ifdef SEVSEG_CAPTURE_DP_EN
            slot_dp_q    <= slot_dp_d;
            dp_q         <= dp_d;
`endif
        end
    end

endmodule
